// File: rtl/spi_master_burst.sv
// SPI master burst engine: modes 0-3, runtime SCK divider, multi-word bursts; SPI_LSB_FIRST_EN selects LSB-first shifting.
// Latency: CS falls one cycle after iStart; each word costs (2*pDataWidth+1)*(iDiv+1) cycles, CS hold adds (iDiv+1).
// Backpressure: between words the engine parks in WAIT with oWdReq high and SCK idle until iWdVd arrives.
module spi_master_burst #(
    parameter int pDataWidth = 8,
    parameter int pLenWidth  = 8,
    parameter int pDivWidth  = 8
) (
    input  logic                  iSCLK,
    input  logic                  iSRST,
    input  logic                  iStart,
    input  logic [pLenWidth-1:0]  iLen,
    input  logic                  iCpol,
    input  logic                  iCpha,
    input  logic [pDivWidth-1:0]  iDiv,
    input  logic [pDataWidth-1:0] iWd,
    input  logic                  iWdVd,
    output logic                  oWdReq,
    output logic [pDataWidth-1:0] oRd,
    output logic                  oRdVd,
    output logic                  oBusy,
    output logic                  oDone,
    output logic                  oSpiSck,
    output logic                  oSpiMosi,
    output logic                  oSpiCs,
    input  logic                  iSpiMiso
);

    localparam int cTogWidth = $clog2(2 * pDataWidth + 1);
    localparam logic [cTogWidth-1:0] cLastTog = cTogWidth'(2 * pDataWidth);
    localparam logic [cTogWidth-1:0] cPenTog  = cTogWidth'(2 * pDataWidth - 1);

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, WAIT, TAIL} stateT;

    stateT                 state;
    logic [pDataWidth-1:0] txSh;
    logic [pDataWidth-1:0] rxSh;
    logic [pLenWidth-1:0]  wordCnt;
    logic [pDivWidth-1:0]  divLat;
    logic [pDivWidth-1:0]  divCnt;
    logic [cTogWidth-1:0]  togCnt;
    logic                  cpol;
    logic                  cpha;

    logic                  tick;
    logic                  doToggle;
    logic                  leading;
    logic                  wdFirst;
    logic                  txCur;
    logic                  txNext;
    logic [pDataWidth-1:0] txShift;
    logic [pDataWidth-1:0] rxNext;

`ifdef SPI_LSB_FIRST_EN
    assign wdFirst = iWd[0];
    assign txCur   = txSh[0];
    assign txNext  = txSh[1];
    assign txShift = {1'b1, txSh[pDataWidth-1:1]};
    assign rxNext  = {iSpiMiso, rxSh[pDataWidth-1:1]};
`else
    assign wdFirst = iWd[pDataWidth-1];
    assign txCur   = txSh[pDataWidth-1];
    assign txNext  = txSh[pDataWidth-2];
    assign txShift = {txSh[pDataWidth-2:0], 1'b1};
    assign rxNext  = {rxSh[pDataWidth-2:0], iSpiMiso};
`endif

    assign tick     = (divCnt == divLat) && (state == SETUP || state == SHIFT || state == TAIL);
    // The SETUP tick produces the first SCK edge; SHIFT ticks produce the rest, then one idle half-period.
    assign doToggle = tick && (state == SETUP || (state == SHIFT && togCnt != cLastTog));
    assign leading  = ~togCnt[0];

    always_ff @(posedge iSCLK) begin
        if (iSRST) begin
            state    <= IDLE;
            txSh     <= '0;
            rxSh     <= '0;
            wordCnt  <= '0;
            divLat   <= '0;
            divCnt   <= '0;
            togCnt   <= '0;
            cpol     <= 1'b0;
            cpha     <= 1'b0;
            oWdReq   <= 1'b0;
            oRd      <= '0;
            oRdVd    <= 1'b0;
            oBusy    <= 1'b0;
            oDone    <= 1'b0;
            oSpiSck  <= 1'b0;
            oSpiMosi <= 1'b1;
            oSpiCs   <= 1'b1;
        end else begin
            oRdVd <= 1'b0;
            oDone <= 1'b0;

            if (tick || state == IDLE || state == WAIT) divCnt <= '0;
            else                                        divCnt <= divCnt + 1'b1;

            if (doToggle) begin
                oSpiSck <= ~oSpiSck;
                togCnt  <= togCnt + 1'b1;
                if (leading == cpha) begin
                    oSpiMosi <= cpha ? txCur : txNext;
                    txSh     <= txShift;
                end else begin
                    rxSh <= rxNext;
                end
                // CPHA=1 takes its final sample on this same edge, so bypass the shifter.
                if (togCnt == cPenTog) begin
                    oRd   <= cpha ? rxNext : rxSh;
                    oRdVd <= 1'b1;
                end
            end

            case (state)
                IDLE: begin
                    oBusy <= 1'b0;
                    if (iStart && !oBusy) begin
                        txSh    <= iWd;
                        wordCnt <= iLen;
                        cpol    <= iCpol;
                        cpha    <= iCpha;
                        divLat  <= iDiv;
                        togCnt  <= '0;
                        oSpiSck <= iCpol;
                        oSpiCs  <= 1'b0;
                        oBusy   <= 1'b1;
                        if (!iCpha) oSpiMosi <= wdFirst;
                        state   <= SETUP;
                    end
                end
                SETUP: begin
                    if (tick) state <= SHIFT;
                end
                SHIFT: begin
                    if (tick && togCnt == cLastTog) begin
                        if (wordCnt == '0) begin
                            state <= TAIL;
                        end else begin
                            wordCnt <= wordCnt - 1'b1;
                            oWdReq  <= 1'b1;
                            state   <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (iWdVd) begin
                        txSh   <= iWd;
                        togCnt <= '0;
                        oWdReq <= 1'b0;
                        if (!cpha) oSpiMosi <= wdFirst;
                        state  <= SETUP;
                    end
                end
                TAIL: begin
                    if (tick) begin
                        oSpiCs   <= 1'b1;
                        oSpiMosi <= 1'b1;
                        oDone    <= 1'b1;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_master_burst.sv
// Bench for spi_master_burst: per-cycle expected pin/handshake values built from burst timing arithmetic.
module tb_spi_master_burst;

    localparam int DW = 8;

    logic          iSCLK = 1'b0;
    logic          iSRST, iStart, iCpol, iCpha, iWdVd, iSpiMiso;
    logic [7:0]    iLen, iDiv;
    logic [DW-1:0] iWd;
    logic          oWdReq, oRdVd, oBusy, oDone, oSpiSck, oSpiMosi, oSpiCs;
    logic [DW-1:0] oRd;

    always #5 iSCLK = ~iSCLK;

    spi_master_burst #(.pDataWidth(DW), .pLenWidth(8), .pDivWidth(8)) dut (
        .iSCLK(iSCLK), .iSRST(iSRST), .iStart(iStart), .iLen(iLen), .iCpol(iCpol),
        .iCpha(iCpha), .iDiv(iDiv), .iWd(iWd), .iWdVd(iWdVd), .oWdReq(oWdReq),
        .oRd(oRd), .oRdVd(oRdVd), .oBusy(oBusy), .oDone(oDone), .oSpiSck(oSpiSck),
        .oSpiMosi(oSpiMosi), .oSpiCs(oSpiCs), .iSpiMiso(iSpiMiso)
    );

    int cyc = 0;
    always @(posedge iSCLK) cyc <= cyc + 1;

    int nChecks = 0;
    int nErr = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nErr++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    function automatic logic txBit(input logic [DW-1:0] w, input int idx);
        if (idx >= DW) return 1'b1;
`ifdef SPI_LSB_FIRST_EN
        return w[idx];
`else
        return w[DW-1-idx];
`endif
    endfunction

    // Slave model: puts bit 0 out at CS fall, advances on trailing (CPHA=0) or leading (CPHA=1) edges.
    logic          useSlave = 1'b0;
    logic          slvCpha = 1'b0;
    logic [DW-1:0] slvWord = '0;
    logic          slvMiso = 1'b1;
    logic          slvPrevSck = 1'b0;
    logic          slvPrevCs = 1'b1;
    int            slvEdges = 0;
    always @(negedge iSCLK) begin
        if (oSpiCs || oWdReq) slvEdges = 0;
        else if (!slvPrevCs && oSpiSck !== slvPrevSck) slvEdges = slvEdges + 1;
        slvPrevSck = oSpiSck;
        slvPrevCs  = oSpiCs;
        slvMiso = txBit(slvWord, slvCpha ? ((slvEdges == 0) ? 0 : (slvEdges - 1) / 2) : slvEdges / 2);
    end
    assign iSpiMiso = useSlave ? slvMiso : oSpiMosi;

    typedef struct {
        logic cs, sck, mosi, mosiCare, busy, done, rdvd, wdreq, rdCare;
        logic [DW-1:0] rd;
    } expT;
    expT expQ [int];

    task automatic putExp(input int c, input logic cs, input logic sck, input logic mosi,
                          input logic mc, input logic busy, input logic done, input logic rdvd,
                          input logic wdreq, input logic rdCare, input logic [DW-1:0] rd);
        expT e;
        e.cs = cs; e.sck = sck; e.mosi = mosi; e.mosiCare = mc; e.busy = busy;
        e.done = done; e.rdvd = rdvd; e.wdreq = wdreq; e.rdCare = rdCare; e.rd = rd;
        expQ[c] = e;
    endtask

    always @(negedge iSCLK) begin
        expT e;
        if (expQ.exists(cyc)) begin
            e = expQ[cyc];
            check("cs", oSpiCs, e.cs);
            check("sck", oSpiSck, e.sck);
            check("busy", oBusy, e.busy);
            check("done", oDone, e.done);
            check("rdvd", oRdVd, e.rdvd);
            check("wdreq", oWdReq, e.wdreq);
            if (e.mosiCare) check("mosi", oSpiMosi, e.mosi);
            if (e.rdCare) check("rd", oRd, e.rd);
        end
    end

    int togTotal = 0, csLowTotal = 0, rdvdTotal = 0, doneTotal = 0;
    int lastRdvdCyc = 0, lastDoneCyc = 0, firstSckCyc = -1;
    logic [DW-1:0] lastRd = '0;
    logic mosiAtFall = 1'b0, monPrevSck = 1'b0, monPrevCs = 1'b1;
    always @(negedge iSCLK) begin
        if (!oSpiCs) csLowTotal++;
        if (!oSpiCs && monPrevCs) begin
            mosiAtFall  = oSpiMosi;
            firstSckCyc = -1;
        end
        if (!oSpiCs && !monPrevCs && oSpiSck !== monPrevSck) begin
            togTotal++;
            if (firstSckCyc < 0) firstSckCyc = cyc;
        end
        if (oRdVd) begin rdvdTotal++; lastRdvdCyc = cyc; lastRd = oRd; end
        if (oDone) begin doneTotal++; lastDoneCyc = cyc; end
        monPrevSck = oSpiSck;
        monPrevCs  = oSpiCs;
    end

    logic [DW-1:0] wordsA [4];
    logic [DW-1:0] rxA [4];
    int stallsA [4];
    int wdAt [4];
    int lastBase = 0;

    // Expected timeline: SETUP h, 2*DW half-periods of h (SCK toggles at the start of each), then WAIT or TAIL.
    task automatic genBurst(input int base, input logic cpol, input logic cpha, input int div,
                            input int len, output int doneCyc);
        int h, s, e;
        h = div + 1;
        s = base + 1;
        doneCyc = 0;
        for (int w = 0; w <= len; w++) begin
            for (int c = s; c < s + h; c++)
                putExp(c, 0, cpol, txBit(wordsA[w], 0), !cpha, 1, 0, 0, 0, 0, '0);
            for (int j = 1; j <= 2 * DW; j++) begin
                for (int c = s + j * h; c < s + (j + 1) * h; c++) begin
                    logic fin;
                    fin = (j == 2 * DW) && (c == s + j * h);
                    putExp(c, 0, cpol ^ (j % 2 == 1),
                           cpha ? txBit(wordsA[w], (j - 1) / 2) : txBit(wordsA[w], j / 2),
                           1, 1, 0, fin, 0, fin, rxA[w]);
                end
            end
            e = s + (2 * DW + 1) * h;
            if (w == len) begin
                for (int c = e; c < e + h; c++) putExp(c, 0, cpol, 1, 0, 1, 0, 0, 0, 0, '0);
                putExp(e + h, 1, cpol, 1, 1, 1, 1, 0, 0, 0, '0);
                putExp(e + h + 1, 1, cpol, 1, 1, 0, 0, 0, 0, 0, '0);
                doneCyc = e + h;
            end else begin
                for (int c = e; c <= e + stallsA[w]; c++) putExp(c, 0, cpol, 1, 0, 1, 0, 0, 1, 0, '0);
                wdAt[w + 1] = e + stallsA[w];
                s = e + stallsA[w] + 1;
            end
        end
    endtask

    task automatic goCycle(input int t);
        while (cyc < t) begin
            @(posedge iSCLK);
            #1;
        end
    endtask

    task automatic startPulse(input int base, input logic cpol, input logic cpha, input int div, input int len);
        iStart = 1'b1; iWd = wordsA[0]; iLen = 8'(len); iCpol = cpol; iCpha = cpha; iDiv = 8'(div);
        goCycle(base + 1);
        iStart = 1'b0; iWd = 8'hE1; iLen = 8'd3; iCpol = ~cpol; iCpha = ~cpha; iDiv = 8'(div) ^ 8'h05;
    endtask

    task automatic runBurst(input logic cpol, input logic cpha, input int div, input int len, input bit noise);
        int base, doneCyc;
        base = cyc;
        lastBase = base;
        genBurst(base, cpol, cpha, div, len, doneCyc);
        startPulse(base, cpol, cpha, div, len);
        if (noise) begin
            goCycle(base + 3);
            iStart = 1'b1; iWdVd = 1'b1; iWd = 8'hC3; iLen = 8'd0;
            goCycle(base + 4);
            iStart = 1'b0; iWdVd = 1'b0;
        end
        for (int w = 1; w <= len; w++) begin
            goCycle(wdAt[w]);
            iWdVd = 1'b1; iWd = wordsA[w];
            goCycle(wdAt[w] + 1);
            iWdVd = 1'b0; iWd = 8'h00;
        end
        goCycle(doneCyc + 1);
    endtask

    initial begin
        #100000;
        nErr++;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $display("Simulation finished: %0d checks, %0d errors", nChecks, nErr);
        $fatal(1);
    end

    initial begin
        int t0, c0, r0, d0, base, dummy;
        iSRST = 1'b1; iStart = 1'b0; iCpol = 1'b0; iCpha = 1'b0; iWdVd = 1'b0;
        iLen = '0; iDiv = '0; iWd = '0;
        for (int c = 1; c <= 4; c++) putExp(c, 1, 0, 1, 1, 0, 0, 0, 0, 1, '0);
        goCycle(3);
        iSRST = 1'b0;
        goCycle(5);

        // Mode 0, div 0, loopback 0xA5
        wordsA[0] = 8'hA5; rxA[0] = 8'hA5;
        t0 = togTotal; c0 = csLowTotal;
        runBurst(0, 0, 0, 0, 0);
        check("t1_toggles", togTotal - t0, 16);
        check("t1_cs_low", csLowTotal - c0, 18);
        check("t1_done_lat", lastDoneCyc - lastBase, 19);
        check("t1_rdvd_lat", lastRdvdCyc - lastBase, 17);
        check("t1_first_sck", firstSckCyc - lastBase, 2);
        check("t1_rd", lastRd, 8'hA5);

        // Mode 3, div 3, slave returns 0x3C
        useSlave = 1'b1; slvCpha = 1'b1; slvWord = 8'h3C;
        wordsA[0] = 8'h96; rxA[0] = 8'h3C;
        t0 = togTotal;
        runBurst(1, 1, 3, 0, 0);
        check("t2_rd", lastRd, 8'h3C);
        check("t2_toggles", togTotal - t0, 16);
        check("t2_first_sck", firstSckCyc - lastBase, 5);
        check("t2_done_lat", lastDoneCyc - lastBase, 73);
        check("t2_sck_idle", oSpiSck, 1);

        // Mode 2, div 2, slave returns 0xE7
        slvCpha = 1'b0; slvWord = 8'hE7;
        wordsA[0] = 8'h18; rxA[0] = 8'hE7;
        runBurst(1, 0, 2, 0, 0);
        check("t3_rd", lastRd, 8'hE7);
        useSlave = 1'b0;

        // Three-word burst, second word held back 5 cycles
        wordsA[0] = 8'h11; wordsA[1] = 8'h22; wordsA[2] = 8'h33;
        rxA[0] = 8'h11; rxA[1] = 8'h22; rxA[2] = 8'h33;
        stallsA[0] = 5; stallsA[1] = 0;
        r0 = rdvdTotal; d0 = doneTotal; c0 = csLowTotal;
        runBurst(0, 0, 1, 2, 0);
        check("t4_rdvd_count", rdvdTotal - r0, 3);
        check("t4_done_count", doneTotal - d0, 1);
        check("t4_cs_low", csLowTotal - c0, 111);
        check("t4_done_lat", lastDoneCyc - lastBase, 112);
        check("t4_rd", lastRd, 8'h33);

        // Reset at toggle 7 with a coincident start
        wordsA[0] = 8'h5A; rxA[0] = 8'h5A;
        base = cyc;
        genBurst(base, 0, 0, 0, 0, dummy);
        startPulse(base, 0, 0, 0, 0);
        r0 = rdvdTotal; d0 = doneTotal;
        goCycle(base + 8);
        iSRST = 1'b1; iStart = 1'b1; iWd = 8'h77; iLen = 8'd0; iCpol = 1'b1; iDiv = 8'd0;
        for (int k = base + 9; k < base + 40; k++) if (expQ.exists(k)) expQ.delete(k);
        putExp(base + 9, 1, 0, 1, 1, 0, 0, 0, 0, 1, '0);
        putExp(base + 10, 1, 0, 1, 1, 0, 0, 0, 0, 1, '0);
        goCycle(base + 9);
        iSRST = 1'b0; iStart = 1'b0;
        goCycle(base + 12);
        check("t5_no_rdvd", rdvdTotal - r0, 0);
        check("t5_no_done", doneTotal - d0, 0);
        wordsA[0] = 8'hC6; rxA[0] = 8'hC6;
        runBurst(0, 0, 0, 0, 0);
        check("t5_rd_after_reset", lastRd, 8'hC6);

        // Mode 1 two-word burst with stray iStart/iWdVd while shifting
        wordsA[0] = 8'h5A; wordsA[1] = 8'hF0; rxA[0] = 8'h5A; rxA[1] = 8'hF0;
        stallsA[0] = 0;
        r0 = rdvdTotal;
        runBurst(0, 1, 1, 1, 1);
        check("t6_rdvd_count", rdvdTotal - r0, 2);
        check("t6_rd", lastRd, 8'hF0);

        // Bit order: 0x01 loopback
        wordsA[0] = 8'h01; rxA[0] = 8'h01;
        runBurst(0, 0, 0, 0, 0);
`ifdef SPI_LSB_FIRST_EN
        check("t7_first_mosi", mosiAtFall, 1);
`else
        check("t7_first_mosi", mosiAtFall, 0);
`endif
        check("t7_rd", lastRd, 8'h01);

        goCycle(cyc + 3);
        $display("Simulation finished: %0d checks, %0d errors", nChecks, nErr);
        $finish;
    end

endmodule

// File: doc/spi_master_burst.md
# spi_master_burst

Parametrised SPI master engine; next generation of the SPI flash single-byte engine in the SPI block. Adds a configurable word width, all four SPI modes, an internal runtime SCK divider and multi-word bursts with CS held low throughout. Sits between the SPI CSR block and the external flash/peripheral pins; the CSR side drives start, length and data words through a valid/request handshake.

## Interface
Parameters:
- pDataWidth, 8: bits per word (4..32).
- pLenWidth, 8: width of burst length field.
- pDivWidth, 8: width of SCK divider field.

Ports:
- iSCLK  in  1  system clock; one clock, all logic on posedge.
- iSRST  in  1  synchronous reset, active-high.
- iStart  in  1  start pulse, sampled in IDLE only.
- iLen  in  pLenWidth  burst length minus one (0 = one word), latched at start.
- iCpol  in  1  SCK idle level, latched at start.
- iCpha  in  1  0: sample on leading edge; 1: sample on trailing edge; latched at start.
- iDiv  in  pDivWidth  SCK half-period = iDiv+1 iSCLK cycles, latched at start.
- iWd  in  pDataWidth  transmit word; first word latched with iStart, later words with iWdVd.
- iWdVd  in  1  next transmit word valid, accepted only while oWdReq=1.
- oWdReq  out  1  engine waiting for next word (level).
- oRd  out  pDataWidth  last received word.
- oRdVd  out  1  one-cycle pulse, oRd updated.
- oBusy  out  1  transfer in progress.
- oDone  out  1  one-cycle pulse, burst complete.
- oSpiSck, oSpiMosi, oSpiCs  out  1 each  external pins; CS active-low.
- iSpiMiso  in  1  external MISO.

## Operation
- States: IDLE, SETUP, SHIFT, WAIT, TAIL.
- Tick: divider counter runs outside IDLE/WAIT, tick when count==latched iDiv, then clears to 0; cleared on every state entry.
- IDLE: CS=1, SCK=latched CPOL, MOSI=1. iStart → latch iWd/iLen/iCpol/iCpha/iDiv, word counter=iLen, go SETUP.
- SETUP: CS=0, SCK=CPOL; MOSI=MSB of word (CPHA=0) or held at previous value (CPHA=1). Tick → SHIFT.
- SHIFT: each tick toggles SCK; 2·pDataWidth ticks per word. Odd toggles = leading edge, even = trailing.
  - CPHA=0: sample MISO into shifter at leading edge, shift MOSI at trailing edge.
  - CPHA=1: drive next MOSI bit at leading edge, sample at trailing edge.
  - After last toggle (SCK back to CPOL): oRd ← received word, oRdVd pulse same cycle. Word counter 0 → TAIL; else decrement, go WAIT.
- WAIT: CS=0, SCK=CPOL, oWdReq=1. iWdVd → load iWd, oWdReq drops next cycle, go SETUP. Indefinite stall allowed.
- TAIL: CS=0 for one half-period (CS hold); tick → IDLE, CS=1, oDone pulse in the same cycle CS rises.
- MOSI fill while shifting: 1.
- iStart outside IDLE ignored; iWdVd outside WAIT ignored; iLen/iDiv/iCpol/iCpha changes after start ignored.

## Timing
- Reset values: oSpiSck 0, oSpiMosi 1, oSpiCs 1, oRd 0, oRdVd 0, oWdReq 0, oBusy 0, oDone 0; state IDLE.
- iStart at cycle 0 → oSpiCs=0, oBusy=1 at cycle 1. First SCK edge at cycle 1+(iDiv+1).
- Word duration 2·pDataWidth·(iDiv+1) cycles; SETUP and TAIL each (iDiv+1).
- Single-word burst, mode 0: iStart to oDone = 1+(2·pDataWidth+2)·(iDiv+1) cycles.
- iDiv=0: SCK = iSCLK/2, all paths functional.
- oBusy high from the cycle after iStart through the oDone cycle inclusive; low again next cycle. New iStart is accepted in the cycle after oDone.
- iSRST mid-burst: next cycle all outputs at reset values, CS=1 immediately, no oDone/oRdVd. iSRST wins over any coincident iStart/iWdVd.
- iWdVd in the first WAIT cycle: SETUP entered next cycle, zero extra gap.

## Configuration
- SPI_LSB_FIRST_EN defined: transmit and receive LSB first; oRd bit 0 = first received bit.
- Undefined: MSB first, oRd MSB = first received bit.

## Test plan
- Mode 0, pDataWidth 8, iDiv 0, MOSI looped to MISO, iWd 0xA5, iLen 0 → 16 SCK toggles, oRd=0xA5, oRdVd then oDone at cycle 19, CS low for 18 cycles.
- Mode 3, iDiv 3, slave model returns 0x3C → SCK idles 1, MOSI changes on falling edges, oRd=0x3C, half-period 4 cycles.
- Burst iLen 2, words 0x11/0x22/0x33, iWdVd delayed 5 cycles on second word → CS stays low throughout, SCK=CPOL during WAIT, three oRdVd pulses, one oDone.
- iSRST asserted at toggle 7 of a word → next cycle CS=1, SCK=0, oBusy=0; a fresh iStart then completes normally.
- iStart pulsed while busy, iWdVd pulsed outside WAIT → ignored; transferred data unchanged.
- Build with SPI_LSB_FIRST_EN, iWd 0x01 loopback → first MOSI bit 1, oRd=0x01.
